// File: rtl/axi4lite_arb.sv
// axi4lite_arb: two-master to one-slave AXI4-Lite arbiter with round-robin selection.
// Only one transaction is in flight; all handshakes pass straight through to the granted master.
module axi4lite_arb (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inport0_awvalid_i,
    input  logic [31:0] inport0_awaddr_i,
    input  logic        inport0_wvalid_i,
    input  logic [31:0] inport0_wdata_i,
    input  logic [3:0]  inport0_wstrb_i,
    input  logic        inport0_bready_i,
    input  logic        inport0_arvalid_i,
    input  logic [31:0] inport0_araddr_i,
    input  logic        inport0_rready_i,
    output logic        inport0_awready_o,
    output logic        inport0_wready_o,
    output logic        inport0_arready_o,
    output logic        inport0_bvalid_o,
    output logic [1:0]  inport0_bresp_o,
    output logic        inport0_rvalid_o,
    output logic [31:0] inport0_rdata_o,
    output logic [1:0]  inport0_rresp_o,
    input  logic        inport1_awvalid_i,
    input  logic [31:0] inport1_awaddr_i,
    input  logic        inport1_wvalid_i,
    input  logic [31:0] inport1_wdata_i,
    input  logic [3:0]  inport1_wstrb_i,
    input  logic        inport1_bready_i,
    input  logic        inport1_arvalid_i,
    input  logic [31:0] inport1_araddr_i,
    input  logic        inport1_rready_i,
    output logic        inport1_awready_o,
    output logic        inport1_wready_o,
    output logic        inport1_arready_o,
    output logic        inport1_bvalid_o,
    output logic [1:0]  inport1_bresp_o,
    output logic        inport1_rvalid_o,
    output logic [31:0] inport1_rdata_o,
    output logic [1:0]  inport1_rresp_o,
    output logic        outport_awvalid_o,
    output logic [31:0] outport_awaddr_o,
    output logic        outport_wvalid_o,
    output logic [31:0] outport_wdata_o,
    output logic [3:0]  outport_wstrb_o,
    output logic        outport_bready_o,
    output logic        outport_arvalid_o,
    output logic [31:0] outport_araddr_o,
    output logic        outport_rready_o,
    input  logic        outport_awready_i,
    input  logic        outport_wready_i,
    input  logic        outport_bvalid_i,
    input  logic [1:0]  outport_bresp_i,
    input  logic        outport_arready_i,
    input  logic        outport_rvalid_i,
    input  logic [31:0] outport_rdata_i,
    input  logic [1:0]  outport_rresp_i,
    output logic [1:0]  grant_o
);
    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_RESP} state_t;
    state_t state_q, state_d;
    logic sel_q, last_q, aw_done_q, w_done_q;
    logic wr0, wr1, req0, req1, pick, pick_wr;
    logic in_wa, in_wr, in_ra, in_rr, aw_hs, w_hs, wr_done;

    assign wr0 = inport0_awvalid_i & inport0_wvalid_i;
    assign wr1 = inport1_awvalid_i & inport1_wvalid_i;
    assign req0 = wr0 | inport0_arvalid_i;
    assign req1 = wr1 | inport1_arvalid_i;
    assign pick = (req0 & req1) ? ~last_q : req1;
    assign pick_wr = pick ? wr1 : wr0;

    assign in_wa = state_q == WR_ADDR;
    assign in_wr = state_q == WR_RESP;
    assign in_ra = state_q == RD_ADDR;
    assign in_rr = state_q == RD_RESP;
    assign aw_hs = outport_awvalid_o & outport_awready_i;
    assign w_hs = outport_wvalid_o & outport_wready_i;
    // address and data may complete in either order or together
    assign wr_done = (aw_done_q | aw_hs) & (w_done_q | w_hs);

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state_q <= IDLE;
            sel_q <= 1'b0;
            last_q <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && (req0 | req1)) begin
                sel_q <= pick;
                last_q <= pick;
            end
            aw_done_q <= in_wa & ~wr_done & (aw_done_q | aw_hs);
            w_done_q <= in_wa & ~wr_done & (w_done_q | w_hs);
        end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req0 | req1) state_d = pick_wr ? WR_ADDR : RD_ADDR;
            WR_ADDR: if (wr_done) state_d = WR_RESP;
            WR_RESP: if (outport_bvalid_i & outport_bready_o) state_d = IDLE;
            RD_ADDR: if (outport_arvalid_o & outport_arready_i) state_d = RD_RESP;
            RD_RESP: if (outport_rvalid_i & outport_rready_o) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign grant_o = (state_q == IDLE) ? 2'b00 : {sel_q, ~sel_q};

    assign outport_awvalid_o = in_wa & ~aw_done_q;
    assign outport_awaddr_o = in_wa ? (sel_q ? inport1_awaddr_i : inport0_awaddr_i) : 32'h0;
    assign outport_wvalid_o = in_wa & ~w_done_q;
    assign outport_wdata_o = in_wa ? (sel_q ? inport1_wdata_i : inport0_wdata_i) : 32'h0;
    assign outport_wstrb_o = in_wa ? (sel_q ? inport1_wstrb_i : inport0_wstrb_i) : 4'h0;
    assign outport_bready_o = in_wr & (sel_q ? inport1_bready_i : inport0_bready_i);
    assign outport_arvalid_o = in_ra;
    assign outport_araddr_o = in_ra ? (sel_q ? inport1_araddr_i : inport0_araddr_i) : 32'h0;
    assign outport_rready_o = in_rr & (sel_q ? inport1_rready_i : inport0_rready_i);

    // the non-granted master sees zeros on every output
    assign inport0_awready_o = grant_o[0] & aw_hs;
    assign inport0_wready_o = grant_o[0] & w_hs;
    assign inport0_arready_o = grant_o[0] & outport_arvalid_o & outport_arready_i;
    assign inport0_bvalid_o = grant_o[0] & in_wr & outport_bvalid_i;
    assign inport0_bresp_o = (grant_o[0] & in_wr) ? outport_bresp_i : 2'b00;
    assign inport0_rvalid_o = grant_o[0] & in_rr & outport_rvalid_i;
    assign inport0_rdata_o = (grant_o[0] & in_rr) ? outport_rdata_i : 32'h0;
    assign inport0_rresp_o = (grant_o[0] & in_rr) ? outport_rresp_i : 2'b00;

    assign inport1_awready_o = grant_o[1] & aw_hs;
    assign inport1_wready_o = grant_o[1] & w_hs;
    assign inport1_arready_o = grant_o[1] & outport_arvalid_o & outport_arready_i;
    assign inport1_bvalid_o = grant_o[1] & in_wr & outport_bvalid_i;
    assign inport1_bresp_o = (grant_o[1] & in_wr) ? outport_bresp_i : 2'b00;
    assign inport1_rvalid_o = grant_o[1] & in_rr & outport_rvalid_i;
    assign inport1_rdata_o = (grant_o[1] & in_rr) ? outport_rdata_i : 32'h0;
    assign inport1_rresp_o = (grant_o[1] & in_rr) ? outport_rresp_i : 2'b00;
endmodule

// File: tb/tb_axi4lite_arb.sv
// tb_axi4lite_arb: directed scenarios plus a randomized run against a transaction-level model
// of the two-master round-robin arbiter.
module tb_axi4lite_arb;
    logic clk = 1'b0, rst;
    logic        m_awvalid[2], m_wvalid[2], m_bready[2], m_arvalid[2], m_rready[2];
    logic [31:0] m_awaddr[2], m_wdata[2], m_araddr[2];
    logic [3:0]  m_wstrb[2];
    logic        m_awready[2], m_wready[2], m_arready[2], m_bvalid[2], m_rvalid[2];
    logic [1:0]  m_bresp[2], m_rresp[2];
    logic [31:0] m_rdata[2];
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;
    logic        o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready;
    logic [31:0] o_awaddr, o_wdata, o_araddr;
    logic [3:0]  o_wstrb;
    logic [1:0]  grant;
    logic        any_out;
    int checks = 0, fails = 0;

    always #5 clk = ~clk;

    axi4lite_arb dut (
        .clk_i(clk), .rst_i(rst),
        .inport0_awvalid_i(m_awvalid[0]), .inport0_awaddr_i(m_awaddr[0]),
        .inport0_wvalid_i(m_wvalid[0]), .inport0_wdata_i(m_wdata[0]), .inport0_wstrb_i(m_wstrb[0]),
        .inport0_bready_i(m_bready[0]), .inport0_arvalid_i(m_arvalid[0]),
        .inport0_araddr_i(m_araddr[0]), .inport0_rready_i(m_rready[0]),
        .inport0_awready_o(m_awready[0]), .inport0_wready_o(m_wready[0]),
        .inport0_arready_o(m_arready[0]), .inport0_bvalid_o(m_bvalid[0]),
        .inport0_bresp_o(m_bresp[0]), .inport0_rvalid_o(m_rvalid[0]),
        .inport0_rdata_o(m_rdata[0]), .inport0_rresp_o(m_rresp[0]),
        .inport1_awvalid_i(m_awvalid[1]), .inport1_awaddr_i(m_awaddr[1]),
        .inport1_wvalid_i(m_wvalid[1]), .inport1_wdata_i(m_wdata[1]), .inport1_wstrb_i(m_wstrb[1]),
        .inport1_bready_i(m_bready[1]), .inport1_arvalid_i(m_arvalid[1]),
        .inport1_araddr_i(m_araddr[1]), .inport1_rready_i(m_rready[1]),
        .inport1_awready_o(m_awready[1]), .inport1_wready_o(m_wready[1]),
        .inport1_arready_o(m_arready[1]), .inport1_bvalid_o(m_bvalid[1]),
        .inport1_bresp_o(m_bresp[1]), .inport1_rvalid_o(m_rvalid[1]),
        .inport1_rdata_o(m_rdata[1]), .inport1_rresp_o(m_rresp[1]),
        .outport_awvalid_o(o_awvalid), .outport_awaddr_o(o_awaddr),
        .outport_wvalid_o(o_wvalid), .outport_wdata_o(o_wdata), .outport_wstrb_o(o_wstrb),
        .outport_bready_o(o_bready), .outport_arvalid_o(o_arvalid),
        .outport_araddr_o(o_araddr), .outport_rready_o(o_rready),
        .outport_awready_i(s_awready), .outport_wready_i(s_wready),
        .outport_bvalid_i(s_bvalid), .outport_bresp_i(s_bresp),
        .outport_arready_i(s_arready), .outport_rvalid_i(s_rvalid),
        .outport_rdata_i(s_rdata), .outport_rresp_i(s_rresp),
        .grant_o(grant)
    );

    assign any_out = |{o_awvalid, o_awaddr, o_wvalid, o_wdata, o_wstrb, o_bready, o_arvalid,
                       o_araddr, o_rready, grant,
                       m_awready[0], m_wready[0], m_arready[0], m_bvalid[0], m_bresp[0],
                       m_rvalid[0], m_rdata[0], m_rresp[0],
                       m_awready[1], m_wready[1], m_arready[1], m_bvalid[1], m_bresp[1],
                       m_rvalid[1], m_rdata[1], m_rresp[1]};

    task automatic clear_inputs();
        for (int n = 0; n < 2; n++) begin
            m_awvalid[n] = 0; m_wvalid[n] = 0; m_bready[n] = 0; m_arvalid[n] = 0; m_rready[n] = 0;
            m_awaddr[n] = 0; m_wdata[n] = 0; m_araddr[n] = 0; m_wstrb[n] = 0;
        end
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_arready = 0; s_rvalid = 0;
        s_bresp = 0; s_rresp = 0; s_rdata = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        m_awvalid[0] = 1; m_wvalid[0] = 1; m_arvalid[1] = 1; m_bready[0] = 1; m_rready[1] = 1;
        s_bvalid = 1; s_rvalid = 1; s_rdata = 32'h1234_5678; s_bresp = 2; s_awready = 1; s_arready = 1;
        repeat (2) cyc();
        checks++;
        if (any_out !== 1'b0) begin fails++; $display("FAIL reset_outputs: any_out=%b required 0", any_out); end
        do_reset();
        #1;
        checks++;
        if (grant !== 2'b00) begin fails++; $display("FAIL reset_grant: grant=%b required 00", grant); end
    endtask

    task automatic test_single_write();
        do_reset();
        m_awvalid[0] = 1; m_awaddr[0] = 32'h9200_0000; m_wvalid[0] = 1;
        m_wdata[0] = 32'hA5A5_0001; m_wstrb[0] = 4'hF; m_bready[0] = 1;
        s_awready = 1; s_wready = 1; s_bvalid = 1; s_bresp = 2'b00;
        #1;
        checks++;
        if ({grant, o_awvalid} !== 3'b000) begin fails++; $display("FAIL wr1_idle: grant/awvalid=%b required 000", {grant, o_awvalid}); end
        cyc();
        checks++;
        if ({grant, o_awvalid, o_wvalid, o_awaddr, o_wdata, o_wstrb, m_awready[0], m_wready[0]}
            !== {2'b01, 1'b1, 1'b1, 32'h9200_0000, 32'hA5A5_0001, 4'hF, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL wr1_addr: grant=%b aw=%b w=%b addr=%h data=%h strb=%h required 01 1 1 92000000 a5a50001 f",
                     grant, o_awvalid, o_wvalid, o_awaddr, o_wdata, o_wstrb);
        end
        cyc();
        m_awvalid[0] = 0; m_wvalid[0] = 0;
        #1;
        checks++;
        if ({m_bvalid[0], m_bresp[0], o_bready, m_bvalid[1], grant} !== {1'b1, 2'b00, 1'b1, 1'b0, 2'b01}) begin
            fails++;
            $display("FAIL wr1_resp: bvalid0=%b bresp0=%b bready=%b bvalid1=%b grant=%b required 1 00 1 0 01",
                     m_bvalid[0], m_bresp[0], o_bready, m_bvalid[1], grant);
        end
        cyc();
        checks++;
        if (grant !== 2'b00) begin fails++; $display("FAIL wr1_back_idle: grant=%b required 00", grant); end
        clear_inputs();
    endtask

    task automatic test_dual_read();
        logic [31:0] rd[2] = '{32'h11, 32'h22};
        do_reset();
        m_arvalid[0] = 1; m_araddr[0] = 32'h100; m_arvalid[1] = 1; m_araddr[1] = 32'h200;
        m_rready[0] = 1; m_rready[1] = 1; s_arready = 1; s_rvalid = 1; s_rresp = 0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (grant !== 2'b00) begin fails++; $display("FAIL rd2_idle%0d: grant=%b required 00", k, grant); end
            cyc();
            s_rdata = rd[k];
            #1;
            checks++;
            if ({grant, o_arvalid, o_araddr, m_arready[k], m_arready[1-k]}
                !== {(k == 0) ? 2'b01 : 2'b10, 1'b1, (k == 0) ? 32'h100 : 32'h200, 1'b1, 1'b0}) begin
                fails++;
                $display("FAIL rd2_addr%0d: grant=%b arvalid=%b araddr=%h", k, grant, o_arvalid, o_araddr);
            end
            cyc();
            m_arvalid[k] = 0;
            #1;
            checks++;
            if ({m_rvalid[k], m_rdata[k], m_rvalid[1-k], m_rdata[1-k]} !== {1'b1, rd[k], 1'b0, 32'h0}) begin
                fails++;
                $display("FAIL rd2_data%0d: rvalid=%b rdata=%h other rvalid=%b rdata=%h required 1 %h 0 0",
                         k, m_rvalid[k], m_rdata[k], m_rvalid[1-k], m_rdata[1-k], rd[k]);
            end
            cyc();
        end
        clear_inputs();
    endtask

    task automatic test_split_write();
        do_reset();
        m_awvalid[1] = 1; m_awaddr[1] = 32'h4000_0010; m_wvalid[1] = 1;
        m_wdata[1] = 32'hCAFE_0003; m_wstrb[1] = 4'h3;
        cyc();
        s_awready = 1;
        #1;
        checks++;
        if ({grant, o_awvalid, o_wvalid, m_awready[1], m_wready[1]} !== 6'b10_1110) begin
            fails++; $display("FAIL split_c1: grant/aw/w/awr/wr=%b required 101110", {grant, o_awvalid, o_wvalid, m_awready[1], m_wready[1]});
        end
        cyc();
        s_awready = 0; m_awvalid[1] = 0;
        #1;
        checks++;
        if ({grant, o_awvalid, o_wvalid} !== 4'b10_01) begin
            fails++; $display("FAIL split_c2: grant/aw/w=%b required 1001", {grant, o_awvalid, o_wvalid});
        end
        cyc();
        s_wready = 1;
        #1;
        checks++;
        if ({o_awvalid, o_wvalid, m_wready[1], o_wdata} !== {3'b011, 32'hCAFE_0003}) begin
            fails++; $display("FAIL split_c3: aw/w/wr=%b wdata=%h required 011 cafe0003", {o_awvalid, o_wvalid, m_wready[1]}, o_wdata);
        end
        cyc();
        m_wvalid[1] = 0; s_wready = 0; s_bvalid = 1; m_bready[1] = 1;
        #1;
        checks++;
        if ({grant, o_awvalid, o_wvalid, m_bvalid[1], o_bready} !== 6'b10_0011) begin
            fails++; $display("FAIL split_c4: grant/aw/w/bvalid/bready=%b required 100011", {grant, o_awvalid, o_wvalid, m_bvalid[1], o_bready});
        end
        cyc();
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        logic [1:0] eg[3] = '{2'b01, 2'b10, 2'b01};
        logic [31:0] ea[3] = '{32'hA000_0000, 32'hB000_0000, 32'hA000_0004};
        do_reset();
        m_awvalid[0] = 1; m_wvalid[0] = 1; m_awaddr[0] = 32'hA000_0000; m_wdata[0] = 1; m_wstrb[0] = 4'hF;
        m_arvalid[1] = 1; m_araddr[1] = 32'hB000_0000;
        m_bready[0] = 1; m_rready[1] = 1;
        s_awready = 1; s_wready = 1; s_arready = 1; s_bvalid = 1; s_rvalid = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (grant !== 2'b00) begin fails++; $display("FAIL b2b_idle%0d: grant=%b required 00", k, grant); end
            cyc();
            checks++;
            if ({grant, o_awvalid, o_arvalid, (k == 1) ? o_araddr : o_awaddr}
                !== {eg[k], k != 1, k == 1, ea[k]}) begin
                fails++;
                $display("FAIL b2b_grant%0d: grant=%b aw=%b ar=%b required %b %b %b addr %h", k, grant,
                         o_awvalid, o_arvalid, eg[k], k != 1, k == 1, ea[k]);
            end
            cyc();
            if (k == 0) begin m_awaddr[0] = 32'hA000_0004; m_wdata[0] = 2; end
            if (k == 1) m_arvalid[1] = 0;
            if (k == 2) begin m_awvalid[0] = 0; m_wvalid[0] = 0; end
            #1;
            checks++;
            if ({grant, m_bvalid[0], m_rvalid[1]} !== {eg[k], k != 1, k == 1}) begin
                fails++; $display("FAIL b2b_resp%0d: grant=%b bvalid0=%b rvalid1=%b", k, grant, m_bvalid[0], m_rvalid[1]);
            end
            cyc();
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        m_awvalid[1] = 1; m_wvalid[1] = 1; m_awaddr[1] = 32'h10; m_wdata[1] = 32'h5; m_wstrb[1] = 4'h1;
        s_awready = 1; s_wready = 1; s_bvalid = 1; s_bresp = 2'b10;
        cyc();
        cyc();
        m_awvalid[1] = 0; m_wvalid[1] = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({o_bready, m_bvalid[1], m_bresp[1], grant} !== 6'b0_1_10_10) begin
                fails++; $display("FAIL bp_hold%0d: bready/bvalid1/bresp1/grant=%b required 011010", i, {o_bready, m_bvalid[1], m_bresp[1], grant});
            end
            cyc();
        end
        m_bready[1] = 1;
        #1;
        checks++;
        if ({o_bready, m_bresp[1]} !== 3'b1_10) begin
            fails++; $display("FAIL bp_accept: bready/bresp1=%b required 110", {o_bready, m_bresp[1]});
        end
        cyc();
        checks++;
        if (grant !== 2'b00) begin fails++; $display("FAIL bp_idle: grant=%b required 00", grant); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_arvalid[0] = 1; m_araddr[0] = 32'h40; s_arready = 1; s_rvalid = 1;
        s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b01;
        cyc();
        cyc();
        m_arvalid[0] = 0;
        #1;
        checks++;
        if ({m_rvalid[0], m_rdata[0], grant} !== {1'b1, 32'hDEAD_BEEF, 2'b01}) begin
            fails++; $display("FAIL rstmid_pre: rvalid0=%b rdata0=%h grant=%b required 1 deadbeef 01", m_rvalid[0], m_rdata[0], grant);
        end
        #1 rst = 1;
        #1;
        checks++;
        if (any_out !== 1'b0) begin fails++; $display("FAIL rstmid_async: any_out=%b required 0", any_out); end
        clear_inputs();
        @(posedge clk);
        #1 rst = 0;
        m_arvalid[0] = 1; m_arvalid[1] = 1; s_arready = 1;
        cyc();
        checks++;
        if (grant !== 2'b01) begin fails++; $display("FAIL rstmid_rr: grant=%b required 01", grant); end
        clear_inputs();
    endtask

    task automatic test_random();
        int cur = 0, oth, mlast = 1, served = 0;
        logic busy = 0, cur_wr = 0, got_aw = 0, got_w = 0, got_ar = 0;
        logic e_aw, e_w, e_ar, e_bv, e_rv, e_bready, e_rready;
        logic outst[2] = '{1'b0, 1'b0};
        logic req[2];
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!outst[n] && $urandom_range(2) == 0) begin
                    outst[n] = 1;
                    if ($urandom_range(1) == 1) begin
                        m_awvalid[n] = 1; m_wvalid[n] = 1;
                        m_awaddr[n] = $urandom; m_wdata[n] = $urandom; m_wstrb[n] = 4'($urandom);
                    end else begin
                        m_arvalid[n] = 1; m_araddr[n] = $urandom;
                    end
                end
                m_bready[n] = 1'($urandom); m_rready[n] = 1'($urandom);
            end
            s_awready = 1'($urandom); s_wready = 1'($urandom); s_arready = 1'($urandom);
            if (got_aw && got_w && !s_bvalid && $urandom_range(1) == 1) begin s_bvalid = 1; s_bresp = 2'($urandom); end
            if (got_ar && !s_rvalid && $urandom_range(1) == 1) begin
                s_rvalid = 1; s_rdata = $urandom; s_rresp = 2'($urandom);
            end
            #1;
            oth = 1 - cur;
            e_aw = busy && cur_wr && m_awvalid[cur];
            e_w = busy && cur_wr && m_wvalid[cur];
            e_ar = busy && !cur_wr && m_arvalid[cur];
            e_bready = busy && cur_wr && !m_awvalid[cur] && !m_wvalid[cur] && m_bready[cur];
            e_rready = busy && !cur_wr && !m_arvalid[cur] && m_rready[cur];
            e_bv = busy && cur_wr && !m_awvalid[cur] && !m_wvalid[cur] && s_bvalid;
            e_rv = busy && !cur_wr && !m_arvalid[cur] && s_rvalid;
            checks++;
            if (!busy) begin
                if (any_out !== 1'b0) begin fails++; $display("FAIL rnd_idle c%0d: any_out=%b grant=%b required 0 00", c, any_out, grant); end
            end else begin
                if ({grant, o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready}
                    !== {cur == 1, cur == 0, e_aw, e_w, e_ar, e_bready, e_rready}) begin
                    fails++;
                    $display("FAIL rnd_ctrl c%0d: grant/aw/w/ar/bready/rready=%b required %b", c,
                             {grant, o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready},
                             {cur == 1, cur == 0, e_aw, e_w, e_ar, e_bready, e_rready});
                end
                checks++;
                if ({m_awready[cur], m_wready[cur], m_arready[cur], m_bvalid[cur], m_rvalid[cur]}
                    !== {e_aw & s_awready, e_w & s_wready, e_ar & s_arready, e_bv, e_rv}) begin
                    fails++;
                    $display("FAIL rnd_master c%0d: awr/wr/arr/bv/rv=%b required %b", c,
                             {m_awready[cur], m_wready[cur], m_arready[cur], m_bvalid[cur], m_rvalid[cur]},
                             {e_aw & s_awready, e_w & s_wready, e_ar & s_arready, e_bv, e_rv});
                end
                checks++;
                if ({m_awready[oth], m_wready[oth], m_arready[oth], m_bvalid[oth], m_bresp[oth],
                     m_rvalid[oth], m_rdata[oth], m_rresp[oth]} !== 41'h0) begin
                    fails++; $display("FAIL rnd_other c%0d: master %0d outputs not zero", c, oth);
                end
                checks++;
                if ((e_aw && o_awaddr !== m_awaddr[cur]) || (e_w && {o_wdata, o_wstrb} !== {m_wdata[cur], m_wstrb[cur]}) ||
                    (e_ar && o_araddr !== m_araddr[cur]) || (e_bv && m_bresp[cur] !== s_bresp) ||
                    (e_rv && {m_rdata[cur], m_rresp[cur]} !== {s_rdata, s_rresp})) begin
                    fails++;
                    $display("FAIL rnd_payload c%0d: awaddr=%h wdata=%h araddr=%h rdata=%h required %h %h %h %h", c,
                             o_awaddr, o_wdata, o_araddr, m_rdata[cur], m_awaddr[cur], m_wdata[cur], m_araddr[cur], s_rdata);
                end
            end
            req[0] = (m_awvalid[0] && m_wvalid[0]) || m_arvalid[0];
            req[1] = (m_awvalid[1] && m_wvalid[1]) || m_arvalid[1];
            cyc();
            if (busy) begin
                if (e_aw && s_awready) begin m_awvalid[cur] = 0; got_aw = 1; end
                if (e_w && s_wready) begin m_wvalid[cur] = 0; got_w = 1; end
                if (e_ar && s_arready) begin m_arvalid[cur] = 0; got_ar = 1; end
                if (e_bready && s_bvalid) begin
                    s_bvalid = 0; got_aw = 0; got_w = 0; outst[cur] = 0; busy = 0; served++;
                end
                if (e_rready && s_rvalid) begin
                    s_rvalid = 0; got_ar = 0; outst[cur] = 0; busy = 0; served++;
                end
            end else if (req[0] || req[1]) begin
                cur = (req[0] && req[1]) ? 1 - mlast : (req[1] ? 1 : 0);
                mlast = cur;
                cur_wr = m_awvalid[cur] && m_wvalid[cur];
                busy = 1;
            end
        end
        checks++;
        if (served < 100) begin fails++; $display("FAIL rnd_progress: served=%0d required >= 100", served); end
        clear_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        test_reset();
        test_single_write();
        test_dual_read();
        test_split_write();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/axi4lite_arb.md
# axi4lite_arb

Two-master to one-slave AXI4-Lite arbiter placed in front of the peripheral distributor, so a second bus master (debug/JTAG bridge or DMA) can share the peripheral register space with the CPU. It serialises traffic: exactly one transaction (one write or one read) is outstanding on the outport at a time. Masters are selected round-robin, and all handshakes are passed through without buffering data.

## Interface
Parameters: none.

Ports (N = 0, 1; each inport line covers both masters):
- clk_i  input  1  system clock
- rst_i  input  1  asynchronous reset, active-high
- inportN_awvalid_i, inportN_awaddr_i  input  1, 32  write address channel from master N
- inportN_wvalid_i, inportN_wdata_i, inportN_wstrb_i  input  1, 32, 4  write data channel from master N
- inportN_bready_i, inportN_arvalid_i, inportN_araddr_i, inportN_rready_i  input  1, 1, 32, 1  response ready and read address from master N
- inportN_awready_o, inportN_wready_o, inportN_arready_o  output  1 each  request-channel readies to master N
- inportN_bvalid_o, inportN_bresp_o  output  1, 2  write response to master N
- inportN_rvalid_o, inportN_rdata_o, inportN_rresp_o  output  1, 32, 2  read response to master N
- outport_awvalid_o, outport_awaddr_o, outport_wvalid_o, outport_wdata_o, outport_wstrb_o  output  1, 32, 1, 32, 4  write request to slave
- outport_bready_o, outport_arvalid_o, outport_araddr_o, outport_rready_o  output  1, 1, 32, 1  to slave
- outport_awready_i, outport_wready_i, outport_bvalid_i, outport_bresp_i  input  1, 1, 1, 2  from slave
- outport_arready_i, outport_rvalid_i, outport_rdata_i, outport_rresp_i  input  1, 1, 32, 2  from slave
- grant_o  output  2  one-hot grant (bit N = master N owns the bus); 0 when idle

## Operation
- Requests per master:
  - write request = awvalid_i & wvalid_i (both must be present).
  - read request = arvalid_i.
  - Within one master, a write wins over a read.
- Round-robin arbitration:
  - last_q holds the last master granted; its reset value is 1, so master 0 wins the first conflict.
  - If both masters request, grant !last_q. If only one requests, grant it.
  - last_q updates on every grant.
- States: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_RESP.
  - IDLE: evaluate requests. Register the grant (G), the type, and last_q. Go to WR_ADDR or RD_ADDR.
  - WR_ADDR:
    - outport_awvalid_o = ~aw_done_q and outport_wvalid_o = ~w_done_q.
    - Address, data and strobe are muxed from inport G.
    - inportG_awready_o = outport_awready_i & ~aw_done_q; wready likewise.
    - aw_done_q and w_done_q set independently on each handshake. When both are complete (registered or same-cycle), go to WR_RESP and clear both flags.
  - WR_RESP:
    - inportG_bvalid_o = outport_bvalid_i; bresp is passed through.
    - outport_bready_o = inportG_bready_i.
    - On the bvalid & bready handshake, go to IDLE.
  - RD_ADDR:
    - outport_arvalid_o = 1; araddr from inport G.
    - inportG_arready_o = outport_arready_i.
    - On the handshake, go to RD_RESP.
  - RD_RESP:
    - rvalid, rdata and rresp pass through to G.
    - outport_rready_o = inportG_rready_i.
    - On the handshake, go to IDLE.
- The non-granted master sees all its ready and valid outputs at 0, and its response data outputs at 0.
- The arbiter relies on masters holding valid and payload stable until accepted (AXI rule). Withdrawing a request after grant is unsupported.
- Response codes (bresp/rresp) pass through unmodified. The arbiter never generates errors.

## Timing
- Reset (async assert, sync release):
  - state = IDLE, grant_o = 0, last_q = 1, aw_done_q = w_done_q = 0.
  - All outport valid/ready outputs are 0, all inport valid/ready outputs are 0, and all data and response outputs are 0.
- Arbitration latency: a request first visible in IDLE at cycle T produces an outport valid at T+1.
- Readies, valids and payloads are combinational pass-through in the active state; the arbiter adds no extra cycle per handshake.
- At least one IDLE cycle separates consecutive transactions. Minimum write: 3 cycles (IDLE, WR_ADDR, WR_RESP with an immediate bvalid). Minimum read: also 3 cycles.
- A request from the losing master that is pending while another transaction is in progress is granted at the next IDLE. There is no starvation: the maximum wait is one transaction.
- Reset asserted mid-transaction returns to IDLE immediately. The slave shares rst_i, so no recovery is required.

## Test plan
- Single write from master 0: aw = 0x9200_0000, wdata = 0xA5A5_0001, wstrb = 0xF, slave ready immediately, bresp = 0 → outport carries the same values at T+1, grant_o = 01, inport0_bvalid_o asserts, back in IDLE after the B handshake.
- Simultaneous reads from both masters just after reset → master 0 is served first (grant_o = 01), then master 1 (grant_o = 10). Each receives only its own rdata (0x11, 0x22). The other master's rvalid stays 0 throughout.
- Split write acceptance: slave raises awready at cycle 1 and wready at cycle 3 → outport_awvalid_o drops after cycle 1, wvalid holds until cycle 3, and WR_RESP is entered at cycle 4.
- Master 0 issues back-to-back writes while master 1 holds a read → grants alternate W0, R1, W0. There is an IDLE cycle between each transaction.
- Back-pressure on the response: slave bvalid is held while inport1_bready_i is low for 5 cycles → outport_bready_o stays 0, the state stays WR_RESP, and bresp = 2 is forwarded unchanged once accepted.
- rst_i pulsed during RD_RESP → all outputs are 0 asynchronously, grant_o = 0, and the next conflict is granted to master 0.
